jk_ubus_arbiter: RTL and testbench
==================================

Name: jk_ubus_arbiter

Overview:
- Central bus controller for the JK UBUS fabric.
- Sequences each bus cycle through arbitration, address and data phases.
- Shares the bus between NUM_MASTERS requesters with round-robin priority.
- Tracks beat count from size/wait_state/error so the next arbitration starts exactly when the current transfer completes. Sits beside the slave and master agents on the shared bus signals.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, consecutive wait_state cycles before abort (optional feature only).

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_MASTERS  per-master bus request.
- read  input  1  bus read strobe (address phase).
- write  input  1  bus write strobe (address phase).
- size  input  2  transfer size code; beats = 1 << size (1,2,4,8).
- bip  input  1  burst-in-progress from active master.
- wait_state  input  1  slave stall; beat not counted when high.
- error  input  1  slave error; terminates transfer.
- gnt  output  NUM_MASTERS  one-hot grant, arbitration cycle only.
- start  output  1  high in every arbitration cycle.
- owner  output  $clog2(NUM_MASTERS)  index of last granted master.
- busy  output  1  high in ADDR and DATA states.
- xfer_done  output  1  one-cycle pulse on completed or aborted transfer.
- proto_err  output  1  one-cycle pulse on bip violation or read&write both high.

Behaviour:
- States: ARB, ADDR, DATA.
- Reset (reset low, async): state=ARB, gnt=0, start=0, owner=0, busy=0, xfer_done=0, proto_err=0, rr pointer=NUM_MASTERS-1, beat counter=0. start is forced 0 while reset is low.
- ARB: start=1.
  - If any req, gnt is one-hot for the first set req searching from pointer+1 with wrap. It is combinational from req in this cycle.
  - At the clock edge: owner and pointer load the winner; go to ADDR.
  - If req=0: gnt=0, stay ARB; start stays high every cycle.
- ADDR (1 cycle): sample read, write, size.
  - read=write=0 (NOP): go to ARB, no xfer_done.
  - read=write=1: proto_err pulse next cycle, go to ARB.
  - Otherwise: latch beats=1<<size, clear counter, go to DATA.
- DATA:
  - Each cycle with wait_state=0 and error=0 counts one beat.
  - bip must be 1 on non-last beats and 0 on the last beat; a mismatch pulses proto_err without aborting.
  - On the counted last beat: xfer_done pulse next cycle, go to ARB.
  - error=1 (any cycle, regardless of wait_state): xfer_done pulse, go to ARB immediately; remaining beats are dropped.
  - error and last beat in the same cycle: treat as error; single xfer_done.
- Latency: minimum bus occupancy is 1 ARB + 1 ADDR + beats; back-to-back transfers need no idle cycle.
- req changes during ADDR/DATA are ignored; the granted master need not hold req.
- Counter width is 4 bits; no wrap is possible since beats ≤ 8.
- Reset mid-transfer returns to ARB with no xfer_done.

Optional Feature:
- Macro: JK_UBUS_ARB_TIMEOUT_EN.
- Defined: a 5-bit counter counts consecutive DATA cycles with wait_state=1 and is cleared by any wait_state=0. On reaching TIMEOUT_CYCLES, the transfer aborts: xfer_done and proto_err pulse together, go to ARB.
- Undefined: no counter; wait_state may stall indefinitely.

Test Plan:
- Release reset with req=4'b0000 -> start=1 every cycle, gnt=0, busy=0, owner=0.
- req=4'b1111 held, four write transfers with size=0 -> gnt order 0001, 0010, 0100, 1000, 0001; each transfer exactly 3 cycles (ARB, ADDR, 1 beat).
- Master 2 read, size=3, wait_state high on beats 2 and 5, bip correct -> busy for 1+8+2=11 cycles; xfer_done one cycle after the 8th counted beat; proto_err=0.
- size=2 transfer with error=1 on beat 2 -> xfer_done next cycle, return to ARB, beats 3-4 never counted.
- size=1 with bip=0 on first beat; then a separate ADDR with read=write=1 -> proto_err pulse for each; ADDR case returns to ARB without DATA.
- Assert reset mid-DATA of a size=3 transfer -> gnt/busy/start 0 immediately. After release, ARB with pointer reset, so master 0 wins over master 1 when both request. With JK_UBUS_ARB_TIMEOUT_EN: wait_state held 16 cycles -> xfer_done+proto_err, return to ARB.

Source files
------------

// File: rtl/jk_ubus_arbiter.sv
// JK UBUS central arbiter: round-robin grant, then ADDR and DATA phases sequenced by beat count.
// Optional wait-state timeout abort is enabled by defining JK_UBUS_ARB_TIMEOUT_EN.
module jk_ubus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           read,
    input  logic                           write,
    input  logic [1:0]                     size,
    input  logic                           bip,
    input  logic                           wait_state,
    input  logic                           error,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic                           start,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           busy,
    output logic                           xfer_done,
    output logic                           proto_err
);

    localparam int PW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_ptr, w_ptr_next;
    logic [PW-1:0]   r_owner, w_owner_next;
    logic [3:0]      r_beats, w_beats_next;
    logic [3:0]      r_beat_cnt, w_beat_cnt_next;
    logic            r_xfer_done, w_xfer_done_next;
    logic            r_proto_err, w_proto_err_next;
`ifdef JK_UBUS_ARB_TIMEOUT_EN
    logic [4:0]      r_to_cnt, w_to_cnt_next;
`endif

    logic            w_any;
    logic [PW-1:0]   w_winner;
    logic            w_arb_live;
    logic            w_last;

    // Position k steps after base, wrapping at NUM_MASTERS.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return PW'(s);
    endfunction

    // Scan farthest-to-nearest so the nearest requester after the pointer wins.
    always_comb begin
        w_any    = |req;
        w_winner = r_ptr;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (req[rr_index(r_ptr, k)]) w_winner = rr_index(r_ptr, k);
        end
    end

    // Reset gates the combinational ARB outputs immediately, not just at the next edge.
    assign w_arb_live = reset && (r_state == ST_ARB);
    assign start      = w_arb_live;
    assign busy       = (r_state != ST_ARB);
    assign owner      = r_owner;
    assign xfer_done  = r_xfer_done;
    assign proto_err  = r_proto_err;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_gnt
            assign gnt[gi] = w_arb_live && w_any && (w_winner == PW'(gi));
        end
    endgenerate

    assign w_last = ((r_beat_cnt + 4'd1) == r_beats);

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_owner_next     = r_owner;
        w_beats_next     = r_beats;
        w_beat_cnt_next  = r_beat_cnt;
        w_xfer_done_next = 1'b0;
        w_proto_err_next = 1'b0;
`ifdef JK_UBUS_ARB_TIMEOUT_EN
        w_to_cnt_next    = r_to_cnt;
`endif
        case (r_state)
            ST_ARB: begin
                if (w_any) begin
                    w_ptr_next   = w_winner;
                    w_owner_next = w_winner;
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (read && write) begin
                    w_proto_err_next = 1'b1;
                    w_state_next     = ST_ARB;
                end else if (!read && !write) begin
                    w_state_next = ST_ARB;
                end else begin
                    w_beats_next    = 4'd1 << size;
                    w_beat_cnt_next = 4'd0;
`ifdef JK_UBUS_ARB_TIMEOUT_EN
                    w_to_cnt_next   = 5'd0;
`endif
                    w_state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (error) begin
                    w_xfer_done_next = 1'b1;
                    w_state_next     = ST_ARB;
                end else if (wait_state) begin
`ifdef JK_UBUS_ARB_TIMEOUT_EN
                    if ((r_to_cnt + 5'd1) == 5'(TIMEOUT_CYCLES)) begin
                        w_xfer_done_next = 1'b1;
                        w_proto_err_next = 1'b1;
                        w_state_next     = ST_ARB;
                    end else begin
                        w_to_cnt_next = r_to_cnt + 5'd1;
                    end
`endif
                end else begin
`ifdef JK_UBUS_ARB_TIMEOUT_EN
                    w_to_cnt_next = 5'd0;
`endif
                    w_beat_cnt_next = r_beat_cnt + 4'd1;
                    // bip must be the inverse of "this is the last beat".
                    if (bip == w_last) w_proto_err_next = 1'b1;
                    if (w_last) begin
                        w_xfer_done_next = 1'b1;
                        w_state_next     = ST_ARB;
                    end
                end
            end
            default: w_state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ARB;
            r_ptr       <= PW'(NUM_MASTERS - 1);
            r_owner     <= '0;
            r_beats     <= 4'd0;
            r_beat_cnt  <= 4'd0;
            r_xfer_done <= 1'b0;
            r_proto_err <= 1'b0;
`ifdef JK_UBUS_ARB_TIMEOUT_EN
            r_to_cnt    <= 5'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_owner     <= w_owner_next;
            r_beats     <= w_beats_next;
            r_beat_cnt  <= w_beat_cnt_next;
            r_xfer_done <= w_xfer_done_next;
            r_proto_err <= w_proto_err_next;
`ifdef JK_UBUS_ARB_TIMEOUT_EN
            r_to_cnt    <= w_to_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_jk_ubus_arbiter.sv
// Bench for jk_ubus_arbiter: directed vector table, async reset sequence, and random
// transactions checked against a transaction-level model (timeout case under JK_UBUS_ARB_TIMEOUT_EN).
module tb_jk_ubus_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'd0;
    logic       read = 1'b0, write = 1'b0;
    logic [1:0] size = 2'd0;
    logic       bip = 1'b0, wait_state = 1'b0, error = 1'b0;
    logic [3:0] gnt;
    logic       start, busy, xfer_done, proto_err;
    logic [1:0] owner;

    jk_ubus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req(req), .read(read), .write(write), .size(size),
        .bip(bip), .wait_state(wait_state), .error(error), .gnt(gnt), .start(start),
        .owner(owner), .busy(busy), .xfer_done(xfer_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rd, wr;
        logic [1:0] sz;
        logic       bip, ws, er;
        logic [3:0] gnt;
        logic       st, bz, done, perr;
        logic [1:0] own;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];
    vec_t rq[$];

    // Model state: last winner, owner, and output pulses due in the next cycle.
    int m_ptr, m_owner;
    bit m_done, m_perr;

    function automatic vec_t mk(logic [3:0] r, logic rd, logic wr, logic [1:0] sz, logic b, logic ws,
                                logic er, logic [3:0] g, logic st, logic bz, logic dn, logic pe,
                                logic [1:0] own);
        vec_t v;
        v.req = r; v.rd = rd; v.wr = wr; v.sz = sz; v.bip = b; v.ws = ws; v.er = er;
        v.gnt = g; v.st = st; v.bz = bz; v.done = dn; v.perr = pe; v.own = own;
        return v;
    endfunction

    function automatic void check(string name, logic [9:0] act, logic [9:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got gnt,start,busy,done,perr,owner=%b required %b", name, act, exp);
    endfunction

    function automatic logic [9:0] outs();
        return {gnt, start, busy, xfer_done, proto_err, owner};
    endfunction

    task automatic apply(input vec_t v, input string name);
        @(posedge clk);
        #1;
        req = v.req; read = v.rd; write = v.wr; size = v.sz;
        bip = v.bip; wait_state = v.ws; error = v.er;
        @(negedge clk);
        check(name, outs(), {v.gnt, v.st, v.bz, v.done, v.perr, v.own});
    endtask

    function automatic void push(logic [3:0] r, logic rd, logic wr, logic [1:0] sz, logic b,
                                 logic ws, logic er, logic [3:0] g, logic st, logic bz);
        rq.push_back(mk(r, rd, wr, sz, b, ws, er, g, st, bz, m_done, m_perr, 2'(m_owner)));
    endfunction

    // Round-robin rule: first requester strictly after the last winner, wrapping.
    function automatic int pick(logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        // Directed table (r,rd,wr,sz,bip,ws,er | gnt,start,busy,done,perr,owner)
        repeat (3) tbl.push_back(mk(4'h0,0,0,0,0,0,0, 4'h0,1,0,0,0,0));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h1,1,0,0,0,0));
        tbl.push_back(mk(4'hF,0,1,0,0,0,0, 4'h0,0,1,0,0,0));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h0,0,1,0,0,0));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h2,1,0,1,0,0));
        tbl.push_back(mk(4'hF,0,1,0,0,0,0, 4'h0,0,1,0,0,1));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h0,0,1,0,0,1));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h4,1,0,1,0,1));
        tbl.push_back(mk(4'hF,0,1,0,0,0,0, 4'h0,0,1,0,0,2));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h0,0,1,0,0,2));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h8,1,0,1,0,2));
        tbl.push_back(mk(4'hF,0,1,0,0,0,0, 4'h0,0,1,0,0,3));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h0,0,1,0,0,3));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h1,1,0,1,0,3));
        tbl.push_back(mk(4'hF,0,0,0,0,0,0, 4'h0,0,1,0,0,0));   // NOP address phase
        tbl.push_back(mk(4'h4,0,0,0,0,0,0, 4'h4,1,0,0,0,0));
        tbl.push_back(mk(4'h0,1,0,3,0,0,0, 4'h0,0,1,0,0,2));   // master 2 read, 8 beats
        tbl.push_back(mk(4'h0,0,0,3,1,0,0, 4'h0,0,1,0,0,2));   // b1
        tbl.push_back(mk(4'h0,0,0,3,1,1,0, 4'h0,0,1,0,0,2));   // wait
        repeat (3) tbl.push_back(mk(4'h0,0,0,3,1,0,0, 4'h0,0,1,0,0,2)); // b2..b4
        tbl.push_back(mk(4'h0,0,0,3,1,1,0, 4'h0,0,1,0,0,2));   // wait
        repeat (3) tbl.push_back(mk(4'h0,0,0,3,1,0,0, 4'h0,0,1,0,0,2)); // b5..b7
        tbl.push_back(mk(4'h0,0,0,3,0,0,0, 4'h0,0,1,0,0,2));   // b8
        tbl.push_back(mk(4'h0,0,0,0,0,0,0, 4'h0,1,0,1,0,2));
        tbl.push_back(mk(4'h2,0,0,0,0,0,0, 4'h2,1,0,0,0,2));
        tbl.push_back(mk(4'h0,0,1,2,0,0,0, 4'h0,0,1,0,0,1));   // 4-beat write
        tbl.push_back(mk(4'h0,0,0,2,1,0,0, 4'h0,0,1,0,0,1));
        tbl.push_back(mk(4'h0,0,0,2,1,0,1, 4'h0,0,1,0,0,1));   // error on beat 2
        tbl.push_back(mk(4'h0,0,0,0,0,0,0, 4'h0,1,0,1,0,1));
        tbl.push_back(mk(4'h8,0,0,0,0,0,0, 4'h8,1,0,0,0,1));
        tbl.push_back(mk(4'h0,1,0,1,0,0,0, 4'h0,0,1,0,0,3));   // 2-beat read
        tbl.push_back(mk(4'h0,0,0,1,0,0,0, 4'h0,0,1,0,0,3));   // bip wrong on beat 1
        tbl.push_back(mk(4'h0,0,0,1,0,0,0, 4'h0,0,1,0,1,3));
        tbl.push_back(mk(4'h1,0,0,0,0,0,0, 4'h1,1,0,1,0,3));
        tbl.push_back(mk(4'h0,1,1,0,0,0,0, 4'h0,0,1,0,0,0));   // read and write together
        tbl.push_back(mk(4'h0,0,0,0,0,0,0, 4'h0,1,0,0,1,0));
        tbl.push_back(mk(4'h0,0,0,0,0,0,0, 4'h0,1,0,0,0,0));

        // Reset held with requests pending: everything quiet.
        req = 4'hF;
        @(negedge clk);
        check("in_reset", outs(), 10'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 4'h0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("dir[%0d]", i));

        // Reset asserted in the middle of an 8-beat transfer.
        apply(mk(4'h2,0,0,0,0,0,0, 4'h2,1,0,0,0,0), "mid_arb");
        apply(mk(4'h0,1,0,3,0,0,0, 4'h0,0,1,0,0,1), "mid_addr");
        apply(mk(4'h0,0,0,3,1,0,0, 4'h0,0,1,0,0,1), "mid_b1");
        apply(mk(4'h0,0,0,3,1,0,0, 4'h0,0,1,0,0,1), "mid_b2");
        #1;
        reset = 1'b0;
        req   = 4'hF;
        #1;
        check("rst_async", outs(), 10'b0);
        @(posedge clk);
        #1;
        check("rst_hold", outs(), 10'b0);
        reset = 1'b1;
        req   = 4'h3;
        @(negedge clk);
        check("rst_release", outs(), {4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        apply(mk(4'h0,0,0,0,0,0,0, 4'h0,0,1,0,0,0), "post_rst_nop");
        apply(mk(4'h0,0,0,0,0,0,0, 4'h0,1,0,0,0,0), "post_rst_idle");

        // Random transactions through the model.
        m_ptr = 0; m_owner = 0; m_done = 0; m_perr = 0;
        for (int t = 0; t < 150; t++) begin
            logic [3:0] r;
            logic       rd, wr, b, er, eb;
            logic [1:0] sz;
            int         w, o, beats, nw;
            bit         ab;
            r = 4'($urandom_range(0, 15));
            if (r == 4'h0) begin
                push(4'h0,0,0,0,0,0,0, 4'h0,1,0);
                m_done = 0; m_perr = 0;
                continue;
            end
            w = pick(r);
            push(r,0,0,0,0,0,0, 4'(1 << w),1,0);
            m_done = 0; m_perr = 0; m_ptr = w; m_owner = w;
            o  = int'($urandom_range(0, 7));
            rd = (o == 1) || (o >= 2 && o < 5);
            wr = (o == 1) || (o >= 5);
            sz = 2'($urandom_range(0, 3));
            push(4'($urandom), rd, wr, sz, 1'($urandom), 1'($urandom), 0, 4'h0,0,1);
            m_perr = rd & wr; m_done = 0;
            if (rd == wr) continue;
            beats = 1 << sz;
            ab = 0;
            for (int i = 0; i < beats && !ab; i++) begin
                nw = int'($urandom_range(0, 4));
                if (nw > 2) nw = 0;
                for (int j = 0; j < nw && !ab; j++) begin
                    er = ($urandom_range(0, 19) == 0);
                    push(4'($urandom),0,0,sz,1'($urandom),1,er, 4'h0,0,1);
                    m_done = er; m_perr = 0; ab = er;
                end
                if (!ab) begin
                    er = ($urandom_range(0, 11) == 0);
                    eb = (i != beats - 1);
                    b  = ($urandom_range(0, 4) == 0) ? !eb : eb;
                    push(4'($urandom),0,0,sz,b,0,er, 4'h0,0,1);
                    if (er) begin
                        m_done = 1; m_perr = 0; ab = 1;
                    end else begin
                        m_done = (i == beats - 1); m_perr = (b != eb);
                    end
                end
            end
        end
`ifdef JK_UBUS_ARB_TIMEOUT_EN
        begin
            int w;
            w = pick(4'h1);
            push(4'h1,0,0,0,0,0,0, 4'(1 << w),1,0);
            m_done = 0; m_perr = 0; m_ptr = w; m_owner = w;
            push(4'h0,0,1,0,0,0,0, 4'h0,0,1);
            for (int j = 0; j < 16; j++) push(4'h0,0,0,0,0,1,0, 4'h0,0,1);
            m_done = 1; m_perr = 1;
        end
`endif
        push(4'h0,0,0,0,0,0,0, 4'h0,1,0);
        for (int i = 0; i < rq.size(); i++) apply(rq[i], $sformatf("rnd[%0d]", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
